// File: rtl/johnson_pkg.sv
// johnson_pkg
// Shared definitions for the Johnson counter phase decoder:
//   - default counter width and rotation-counter width
//   - lock FSM state encoding
//   - jc_index(): maps a Johnson code to {legal, index}
//   - jc_succ():  successor index in the rotation (wraps 2*stages-1 -> 0)
package johnson_pkg;

  localparam int JC_STAGES     = 4;
  localparam int JC_CYC_W      = 8;
  localparam int JC_MAX_STAGES = 16;

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    LOCK   = 2'd1,
    FAULT  = 2'd2
  } lock_state_t;

  typedef struct packed {
    logic       legal;
    logic [7:0] idx;
  } jc_info_t;

  // Index k < stages is k ones filled from the LSB; index k >= stages is
  // (2*stages - k) ones aligned to the MSB, i.e. the full mask with the low
  // (k - stages) bits cleared. The code is legal if it matches any pattern.
  function automatic jc_info_t jc_index(input logic [31:0] code, input int stages);
    jc_info_t    info;
    logic [31:0] full;
    logic [31:0] pattern;
    info.legal = 1'b0;
    info.idx   = '0;
    full       = (32'd1 << stages) - 32'd1;
    for (int k = 0; k < 2 * JC_MAX_STAGES; k++) begin
      pattern = '0;
      if (k < 2 * stages) begin
        if (k < stages) begin
          pattern = (32'd1 << k) - 32'd1;
        end else begin
          pattern = full & ~((32'd1 << (k - stages)) - 32'd1);
        end
        if (!info.legal && (code == pattern)) begin
          info.legal = 1'b1;
          info.idx   = k[7:0];
        end
      end
    end
    return info;
  endfunction

  function automatic logic [7:0] jc_succ(input logic [7:0] idx, input int stages);
    logic [7:0] nxt;
    if (int'(idx) == 2 * stages - 1) begin
      nxt = 8'd0;
    end else begin
      nxt = idx + 8'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// johnson_code_check
// Purely combinational classifier for one Johnson counter sample.
// Ports:
//   jc_in  - raw counter sample (bit 0 is the stage fed by the inverted MSB)
//   legal  - sample is one of the 2*STAGES legal codes
//   idx    - phase index of the sample (0 when illegal)
//   onehot - one-hot phase of the sample (all zero when illegal)
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int STAGES = JC_STAGES
) (
  input  logic [STAGES-1:0]             jc_in,
  output logic                          legal,
  output logic [$clog2(2*STAGES)-1:0]   idx,
  output logic [2*STAGES-1:0]           onehot
);

  localparam int IDX_W = $clog2(2 * STAGES);

  jc_info_t info;
  logic     unused_idx_hi;

  always_comb begin
    info   = jc_index({{(32 - STAGES){1'b0}}, jc_in}, STAGES);
    legal  = info.legal;
    idx    = info.idx[IDX_W-1:0];
    onehot = '0;
    if (info.legal) begin
      onehot[info.idx[IDX_W-1:0]] = 1'b1;
    end
  end

  // The package index is wider than this instance needs.
  assign unused_idx_hi = ^info.idx[7:IDX_W];

endmodule

// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder
// Decodes a Johnson counter sample into a one-hot phase and a binary index,
// tracks sequence integrity with a UNLOCK/LOCK/FAULT FSM and counts
// completed rotations. All outputs are registered (one cycle latency).
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   jc_in     - Johnson counter sample
//   clr_err   - clears sticky seq_err and releases FAULT
//   phase_oh  - one-hot phase, zero unless locked
//   phase_idx - binary phase index, zero unless locked
//   locked    - FSM is in LOCK
//   stall     - pulse: locked sample repeated the previous one
//   wrap      - pulse: index went last -> 0 while locked
//   seq_err   - sticky sequence / illegal-code error
//   cyc_cnt   - saturating count of completed rotations
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter int STAGES = JC_STAGES,
  parameter int CYC_W  = JC_CYC_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [STAGES-1:0]            jc_in,
  input  logic                         clr_err,
  output logic [2*STAGES-1:0]          phase_oh,
  output logic [$clog2(2*STAGES)-1:0]  phase_idx,
  output logic                         locked,
  output logic                         stall,
  output logic                         wrap,
  output logic                         seq_err,
  output logic [CYC_W-1:0]             cyc_cnt
);

  localparam int                IDX_W   = $clog2(2 * STAGES);
  localparam int                PAD_W   = 8 - IDX_W;
  localparam logic [CYC_W-1:0]  CNT_MAX = '1;
  localparam logic [CYC_W-1:0]  CNT_ONE = {{(CYC_W - 1){1'b0}}, 1'b1};

  lock_state_t              state, state_nxt;
  logic [STAGES-1:0]        prev_code;
  logic                     prev_legal;
  logic [IDX_W-1:0]         prev_idx;

  logic                     cur_legal;
  logic [IDX_W-1:0]         cur_idx;
  logic [2*STAGES-1:0]      cur_oh;

  logic                     is_succ;
  logic                     is_same;
  logic                     locked_nxt;
  logic                     stall_nxt;
  logic                     wrap_nxt;
  logic                     seq_err_nxt;
  logic [2*STAGES-1:0]      phase_oh_nxt;
  logic [IDX_W-1:0]         phase_idx_nxt;

  johnson_code_check #(.STAGES(STAGES)) u_check (
    .jc_in  (jc_in),
    .legal  (cur_legal),
    .idx    (cur_idx),
    .onehot (cur_oh)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UNLOCK;
    end else begin
      state <= state_nxt;
    end
  end

  // The previous sample's classification is kept from the single checker
  // instance, so successor tests never need a second decoder.
  always_comb begin
    is_succ = cur_legal && prev_legal &&
              ({{PAD_W{1'b0}}, cur_idx} == jc_succ({{PAD_W{1'b0}}, prev_idx}, STAGES));
    is_same = cur_legal && prev_legal && (jc_in == prev_code);

    state_nxt   = state;
    seq_err_nxt = seq_err;
    stall_nxt   = 1'b0;
    wrap_nxt    = 1'b0;

    case (state)
      UNLOCK: begin
        if (clr_err) seq_err_nxt = 1'b0;
        if (is_succ) state_nxt = LOCK;
      end
      LOCK: begin
        if (is_succ) begin
          if (clr_err) seq_err_nxt = 1'b0;
          wrap_nxt = (cur_idx == '0);
        end else if (is_same) begin
          if (clr_err) seq_err_nxt = 1'b0;
          stall_nxt = 1'b1;
        end else begin
          // A detected error takes priority over a simultaneous clear.
          state_nxt   = FAULT;
          seq_err_nxt = 1'b1;
        end
      end
      FAULT: begin
        if (clr_err) begin
          seq_err_nxt = 1'b0;
          state_nxt   = UNLOCK;
        end
      end
      default: state_nxt = UNLOCK;
    endcase

    locked_nxt    = (state_nxt == LOCK);
    phase_oh_nxt  = locked_nxt ? cur_oh  : '0;
    phase_idx_nxt = locked_nxt ? cur_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_code  <= '0;
      prev_legal <= 1'b0;
      prev_idx   <= '0;
      phase_oh   <= '0;
      phase_idx  <= '0;
      locked     <= 1'b0;
      stall      <= 1'b0;
      wrap       <= 1'b0;
      seq_err    <= 1'b0;
      cyc_cnt    <= '0;
    end else begin
      prev_code  <= jc_in;
      prev_legal <= cur_legal;
      prev_idx   <= cur_idx;
      phase_oh   <= phase_oh_nxt;
      phase_idx  <= phase_idx_nxt;
      locked     <= locked_nxt;
      stall      <= stall_nxt;
      wrap       <= wrap_nxt;
      seq_err    <= seq_err_nxt;
      if (wrap_nxt && (cyc_cnt != CNT_MAX)) begin
        cyc_cnt <= cyc_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// tb_johnson_phase_decoder
// Drives two decoders (CYC_W=8 and CYC_W=2) with the same sample stream and
// compares every output each cycle against a behavioural model built from
// the legal-code table, plus hand-computed expectations at key points.
module tb_johnson_phase_decoder;

  logic       clk;
  logic       rst;
  logic       clr_err;
  logic [3:0] jc_in;

  logic [7:0] a_phase_oh, b_phase_oh;
  logic [2:0] a_phase_idx, b_phase_idx;
  logic       a_locked, b_locked;
  logic       a_stall, b_stall;
  logic       a_wrap, b_wrap;
  logic       a_seq_err, b_seq_err;
  logic [7:0] a_cyc_cnt;
  logic [1:0] b_cyc_cnt;

  int checks = 0;
  int errors = 0;

  localparam int M_UNLOCK = 0;
  localparam int M_LOCK   = 1;
  localparam int M_FAULT  = 2;

  int         mState     = M_UNLOCK;
  bit         mErr       = 1'b0;
  int         mCntA      = 0;
  int         mCntB      = 0;
  logic [3:0] mPrevCode  = 4'd0;
  bit         mPrevLegal = 1'b0;
  int         mPrevIdx   = 0;
  bit         eStall     = 1'b0;
  bit         eWrap      = 1'b0;
  bit         eLocked    = 1'b0;
  int         eIdx       = 0;
  logic [7:0] eOh        = 8'd0;

  johnson_phase_decoder #(.STAGES(4), .CYC_W(8)) dut_a (
    .clk(clk), .rst(rst), .jc_in(jc_in), .clr_err(clr_err),
    .phase_oh(a_phase_oh), .phase_idx(a_phase_idx), .locked(a_locked),
    .stall(a_stall), .wrap(a_wrap), .seq_err(a_seq_err), .cyc_cnt(a_cyc_cnt)
  );

  johnson_phase_decoder #(.STAGES(4), .CYC_W(2)) dut_b (
    .clk(clk), .rst(rst), .jc_in(jc_in), .clr_err(clr_err),
    .phase_oh(b_phase_oh), .phase_idx(b_phase_idx), .locked(b_locked),
    .stall(b_stall), .wrap(b_wrap), .seq_err(b_seq_err), .cyc_cnt(b_cyc_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Legal code for rotation position k: k ones from the LSB for the first
  // half, then a shrinking block of ones held against the MSB.
  function automatic logic [3:0] codeOf(input int k);
    int v;
    if (k < 4) v = (1 << k) - 1;
    else       v = (15 << (k - 4)) & 15;
    return v[3:0];
  endfunction

  function automatic int idxOf(input logic [3:0] c);
    int r;
    r = -1;
    for (int k = 0; k < 8; k++) begin
      if (codeOf(k) == c) r = k;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] code, input logic clr, input logic r);
    @(negedge clk);
    jc_in   = code;
    clr_err = clr;
    rst     = r;
    @(posedge clk);
    #2;
  endtask

  // Reference model: advance on every edge, then compare shortly after.
  always @(posedge clk) begin
    int  ci;
    bit  leg, succ, same;
    ci = idxOf(jc_in);
    leg = (ci >= 0);
    eStall = 1'b0;
    eWrap  = 1'b0;
    if (rst) begin
      mState = M_UNLOCK; mErr = 1'b0; mCntA = 0; mCntB = 0;
      mPrevCode = 4'd0; mPrevLegal = 1'b0; mPrevIdx = 0;
    end else begin
      succ = leg && mPrevLegal && (ci == (mPrevIdx + 1) % 8);
      same = leg && mPrevLegal && (jc_in == mPrevCode);
      if (mState == M_LOCK) begin
        if (succ) begin
          if (clr_err) mErr = 1'b0;
          if (ci == 0) begin
            eWrap = 1'b1;
            if (mCntA < 255) mCntA++;
            if (mCntB < 3)   mCntB++;
          end
        end else if (same) begin
          if (clr_err) mErr = 1'b0;
          eStall = 1'b1;
        end else begin
          mState = M_FAULT;
          mErr   = 1'b1;
        end
      end else if (mState == M_UNLOCK) begin
        if (clr_err) mErr = 1'b0;
        if (succ) mState = M_LOCK;
      end else begin
        if (clr_err) begin
          mErr   = 1'b0;
          mState = M_UNLOCK;
        end
      end
      mPrevCode  = jc_in;
      mPrevLegal = leg;
      mPrevIdx   = ci;
    end
    eLocked = (mState == M_LOCK);
    eIdx    = eLocked ? ci : 0;
    eOh     = eLocked ? (8'd1 << eIdx) : 8'd0;
    #1;
    checkOutput("a_phase_oh",  a_phase_oh,  eOh);
    checkOutput("a_phase_idx", a_phase_idx, eIdx);
    checkOutput("a_locked",    a_locked,    eLocked);
    checkOutput("a_stall",     a_stall,     eStall);
    checkOutput("a_wrap",      a_wrap,      eWrap);
    checkOutput("a_seq_err",   a_seq_err,   mErr);
    checkOutput("a_cyc_cnt",   a_cyc_cnt,   mCntA);
    checkOutput("b_locked",    b_locked,    eLocked);
    checkOutput("b_wrap",      b_wrap,      eWrap);
    checkOutput("b_seq_err",   b_seq_err,   mErr);
    checkOutput("b_cyc_cnt",   b_cyc_cnt,   mCntB);
  end

  initial begin
    logic [3:0] code;
    int         g;
    int         r;
    rst     = 1'b1;
    jc_in   = 4'd0;
    clr_err = 1'b0;

    // Reset for two cycles.
    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("pin_reset_locked", a_locked, 0);
    checkOutput("pin_reset_oh", a_phase_oh, 0);
    checkOutput("pin_reset_cnt", a_cyc_cnt, 0);

    // Clean rotation.
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("pin_first_sample_unlocked", a_locked, 0);
    applyStimulus(4'b0011, 1'b0, 1'b0);
    checkOutput("pin_lock_rise", a_locked, 1);
    checkOutput("pin_lock_idx", a_phase_idx, 2);
    checkOutput("pin_lock_oh", a_phase_oh, 8'b0000_0100);
    applyStimulus(4'b0111, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b1110, 1'b0, 1'b0);
    applyStimulus(4'b1100, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    checkOutput("pin_no_early_wrap", a_wrap, 0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("pin_wrap", a_wrap, 1);
    checkOutput("pin_cnt_one", a_cyc_cnt, 1);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("pin_wrap_single", a_wrap, 0);

    // Illegal code while locked, then legal codes stay in FAULT.
    applyStimulus(4'b0011, 1'b0, 1'b0);
    applyStimulus(4'b0111, 1'b0, 1'b0);
    applyStimulus(4'b0101, 1'b0, 1'b0);
    checkOutput("pin_illegal_locked", a_locked, 0);
    checkOutput("pin_illegal_err", a_seq_err, 1);
    checkOutput("pin_illegal_oh", a_phase_oh, 0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("pin_fault_sticky", a_locked, 0);

    // Clear then relock.
    applyStimulus(4'b0011, 1'b1, 1'b0);
    checkOutput("pin_clear_err", a_seq_err, 0);
    applyStimulus(4'b1100, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    checkOutput("pin_relock", a_locked, 1);
    checkOutput("pin_relock_idx", a_phase_idx, 7);

    // Skip code.
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0011, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("pin_skip_err", a_seq_err, 1);
    checkOutput("pin_skip_locked", a_locked, 0);

    // Stall, then clear together with an illegal code.
    applyStimulus(4'b0111, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b1110, 1'b0, 1'b0);
    applyStimulus(4'b1110, 1'b0, 1'b0);
    checkOutput("pin_stall_1", a_stall, 1);
    applyStimulus(4'b1110, 1'b0, 1'b0);
    checkOutput("pin_stall_2", a_stall, 1);
    checkOutput("pin_stall_idx", a_phase_idx, 5);
    applyStimulus(4'b1100, 1'b0, 1'b0);
    checkOutput("pin_stall_end", a_stall, 0);
    applyStimulus(4'b1010, 1'b1, 1'b0);
    checkOutput("pin_err_beats_clr", a_seq_err, 1);
    checkOutput("pin_err_beats_clr_lock", a_locked, 0);

    // Five full rotations, saturating the narrow counter.
    applyStimulus(4'b0000, 1'b1, 1'b0);
    for (int rot = 0; rot < 5; rot++) begin
      for (int k = 1; k <= 8; k++) begin
        applyStimulus(codeOf(k % 8), 1'b0, 1'b0);
      end
    end
    checkOutput("pin_saturated", b_cyc_cnt, 3);

    // Reset in the middle of a rotation.
    applyStimulus(4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0011, 1'b0, 1'b1);
    checkOutput("pin_midreset_locked", a_locked, 0);
    checkOutput("pin_midreset_cnt", a_cyc_cnt, 0);
    checkOutput("pin_midreset_oh", a_phase_oh, 0);

    // Randomized traffic: mostly clean rotation, with holds, jumps,
    // corrupt codes, clears and occasional resets.
    g    = 1;
    code = 4'b0011;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 75) begin
        g    = (g + 1) % 8;
        code = codeOf(g);
      end else if (r < 85) begin
        code = code;
      end else if (r < 93) begin
        code = 4'($urandom_range(0, 15));
        if (idxOf(code) >= 0) g = idxOf(code);
      end else begin
        g    = $urandom_range(0, 7);
        code = codeOf(g);
      end
      applyStimulus(code, ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    applyStimulus(4'b0000, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/johnson_phase_decoder.md
# johnson_phase_decoder

Downstream consumer of the 4-stage Johnson (twisted-ring) counter.
- Samples the counter's parallel output every clock and decodes it into a one-hot phase bus plus a binary phase index.
- Monitors sequence integrity through a three-state lock FSM and counts completed rotations.
- Sits between the counter and the phase-driven logic (mux selects, strobe generation) and isolates that logic from corrupted or illegal codes.

## Interface
Parameters:
- `STAGES`, default 4: Johnson counter width; legal codes = 2*STAGES.
- `CYC_W`, default 8: width of the rotation counter.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `jc_in`, input, STAGES: counter output; bit 0 is the stage fed by the inverted MSB.
- `clr_err`, input, 1: clears the sticky error and leaves FAULT.
- `phase_oh`, output, 2*STAGES: one-hot phase; all zero when not LOCKED.
- `phase_idx`, output, clog2(2*STAGES): binary phase index; 0 when not LOCKED.
- `locked`, output, 1: high while the FSM is in LOCK.
- `stall`, output, 1: one-cycle pulse when a LOCKED sample equals the previous sample.
- `wrap`, output, 1: one-cycle pulse on the index transition 2*STAGES-1 -> 0 while LOCKED.
- `seq_err`, output, 1: sticky sequence or illegal-code error.
- `cyc_cnt`, output, CYC_W: completed rotations; saturating.

## Operation
Code map (STAGES=4). Sequence order, with index k for each code:
- 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7.
- Every other code is illegal.
- In general, index k<STAGES is k ones filled from the LSB; index k>=STAGES is (2*STAGES-k) ones aligned to the MSB.
- The successor of index k is (k+1) mod 2*STAGES.

Internal registers: `prev_code`, `prev_legal`, FSM state.

FSM states:
- UNLOCK (reset state):
  - Go to LOCK when the current sample is legal, `prev_legal`=1, and idx(current) = successor(idx(prev)).
  - Otherwise stay. Illegal codes in UNLOCK do not set `seq_err`.
- LOCK:
  - Successor sample: stay, update outputs.
  - Equal sample: stay, pulse `stall`, outputs unchanged.
  - Illegal code or any other legal code: go to FAULT and set `seq_err`.
- FAULT:
  - Outputs `phase_oh`/`phase_idx`/`locked` forced to 0.
  - `clr_err`=1 clears `seq_err` and goes to UNLOCK.

Rotation counter: `cyc_cnt` increments on each `wrap`, saturates at 2^CYC_W-1, and is cleared only by `rst`.

Boundary rules:
- Error and `clr_err` in the same cycle (LOCK): the error wins; the FSM enters FAULT with `seq_err`=1.
- `clr_err` in UNLOCK or LOCK: clears `seq_err` only; no state change.
- `rst` mid-rotation: all state returns to reset values on that edge. `cyc_cnt` is lost.
- Entering LOCK with sample index 0 from index 2*STAGES-1 does not pulse `wrap`; `wrap` requires the previous state to be LOCK.

## Timing
- Reset values: all outputs 0, FSM = UNLOCK, `prev_legal`=0, `prev_code`=0.
- Latency is one cycle: `jc_in` sampled at edge N is reflected on all outputs after edge N.
- Lock acquisition takes the earliest two consecutive legal successive samples. `locked` rises after the edge that captures the second sample.
- `stall` and `wrap` are registered and are high for exactly one cycle per event.
- Fault detection: `locked` falls and `seq_err` rises after the same edge that captures the bad sample.
- No combinational path from inputs to outputs.

## Structure
Package `johnson_pkg` holds:
- the FSM state enum (UNLOCK, LOCK, FAULT);
- the `STAGES`/`CYC_W` defaults;
- a function `jc_index(code) -> {legal, idx}`;
- a function `jc_succ(idx)`.

Sub-module `johnson_code_check` is combinational: `jc_in` -> legal, idx, one-hot. It is instantiated once for the current sample.
- The previous sample's legality and index are registered from this sub-module's outputs; there is no second instance.

The top level holds the FSM, the registers and the rotation counter.

## Test plan
- **Reset, then clean sequence:** `rst`=1 for 2 cycles, then drive 0001,0011,0111,1111,1110,1100,1000,0000,0001. Expect:
  - `locked`=1 after the edge capturing 0011;
  - `phase_idx`=2 with `phase_oh`=8'b0000_0100;
  - a single `wrap` after the edge capturing 0000;
  - `cyc_cnt`=1.
- **Illegal code while LOCKED:** drive 0101 after 0111. Expect:
  - after the same edge: `locked`=0, `seq_err`=1, `phase_oh`=0;
  - legal codes that follow keep the block in FAULT until `clr_err`.
- **Skip code:** drive 0011 then 1111 while LOCKED. Expect FAULT and `seq_err`=1.
- **Clear then relock:** pulse `clr_err`, then drive 1100,1000. Expect `seq_err`=0 after the pulse and `locked`=1 after the edge capturing 1000, with `phase_idx`=7.
- **Stall and simultaneous events:**
  - Hold 1110 for 3 cycles while LOCKED. Expect `stall` high on 2 cycles, `phase_idx` held at 5, no error.
  - Assert `clr_err` together with an illegal code. Expect `seq_err`=1 and FAULT.
- **Saturation and mid-run reset:** with CYC_W=2, run 5 full rotations. Expect `cyc_cnt` stuck at 3. Then `rst`=1 mid-rotation. Expect all outputs 0 on the next cycle.
